fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 stall_i  in  1  downstream decode cannot accept ir_o this cycle.
REQ-005 redirect_i  in  1  taken BEQ/JMP from execute; flushes the stage.
REQ-006 redirect_pc_i  in  32  byte address of the new fetch target.
REQ-007 imem_req_o  out  1  instruction memory request.
REQ-008 imem_addr_o  out  32  byte address of the requested word.
REQ-009 imem_ack_i  in  1  memory returns imem_data_i this cycle; variable latency of 1 or more cycles.
REQ-010 imem_data_i  in  32  instruction word, {op[31:26], Ri[25:21], Rj[20:16], Rk[15:11], imm[15:0]}.
REQ-011 ir_o  out  32  instruction presented to decode.
REQ-012 pc_o  out  32  byte address of ir_o.
REQ-013 valid_o  out  1  ir_o/pc_o hold a live instruction.

Function
REQ-014 FSM states SHALL be IDLE, REQ and FULL.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-016 In REQ: imem_req_o=1 and imem_addr_o=fetch_pc; both held stable until imem_ack_i.
REQ-017 Output slot free = !valid_o || !stall_i; an instruction is consumed on a cycle where valid_o && !stall_i.
REQ-018 Ack in REQ with slot free SHALL load ir_o, pc_o and valid_o=1 on that edge, advance fetch_pc by 4, and stay in REQ.
REQ-019 Ack in REQ with slot occupied (valid_o && stall_i) SHALL store data and pc in a one-entry skid register, advance fetch_pc, and go to FULL.
REQ-020 In FULL, imem_req_o SHALL be 0; when the slot frees, the skid contents move to ir_o/pc_o with valid_o=1 and the FSM returns to REQ.
REQ-021 Stall SHALL hold ir_o, pc_o and valid_o unchanged.
REQ-022 fetch_pc SHALL wrap modulo 2^32; an increment past 32'hFFFF_FFFC gives 0.
REQ-023 A redirect with no outstanding request SHALL set fetch_pc=redirect_pc_i and clear valid_o and the skid on the next edge; state becomes REQ.
REQ-024 A redirect while a request is outstanding (REQ with no ack yet) SHALL set a kill flag; the matching ack is discarded (no output update), the kill flag clears, and the next request uses the redirect address.
REQ-025 A redirect in the same cycle as an ack SHALL discard that ack's data; the next request uses redirect_pc_i.
REQ-026 Redirect SHALL take priority over stall and ack; a second redirect before the kill completes overwrites the target.
REQ-027 At most one request SHALL be outstanding; throughput is 1 instruction/cycle when ack latency is 1 and stall is 0.
REQ-028 The stage SHALL NOT interpret opcodes; BEQ (100000) and JMP (100001) resolve downstream.

Reset
REQ-029 While rst_n=0: state=IDLE, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, ir_o=0, pc_o=0, valid_o=0, skid empty, kill=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; any ack arriving in IDLE SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, RESET_PC default, PC_STEP=4, and the opcode constants OP_BEQ and OP_JMP for the decode and execute stages.
REQ-032 The skid register SHALL be a sub-module named fetch_skid (data, pc, full flag; load, unload and clear controls).

Verification
REQ-033 Reset, ack latency 1, no stall -> valid_o rises 2 cycles after reset release; pc_o sequence 0, 4, 8, 12 on consecutive cycles.
REQ-034 stall_i held high for 3 cycles with ack latency 1 -> ir_o/pc_o frozen, one extra word in skid, imem_req_o=0; on release pc_o steps 8, 12 on consecutive cycles with no loss and no duplicate.
REQ-035 Ack latency 3, redirect_i=1 with redirect_pc_i=32'h40 one cycle after the request to 8 -> data from 8 is never presented; the next valid_o shows pc_o=32'h40.
REQ-036 Redirect in the same cycle as an ack, target 32'h100 -> valid_o=0 next cycle; the next valid pc_o=32'h100.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_n pulsed low during an outstanding request with a late ack -> all outputs return to reset values; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Types and constants shared by the fetch stage and the stages behind it.
//   fetch_state_t    : fetch FSM state encoding
//   RESET_PC_DEFAULT : default address of the first fetch after reset
//   PC_STEP          : byte distance between consecutive instruction words
//   OP_BEQ / OP_JMP  : opcodes resolved in decode/execute, not used by fetch
//   next_pc()        : sequential successor of a fetch address, wraps mod 2^32
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100001;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Instruction memory bus between the fetch stage and instruction memory.
//   imem_req_o  : request, held with imem_addr_o until imem_ack_i
//   imem_addr_o : byte address of the requested word
//   imem_ack_i  : memory returns imem_data_i this cycle
//   imem_data_i : instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );

endinterface

// File: rtl/fetch_skid.sv
// fetch_skid
// One-entry holding register for an instruction that returned from memory
// while the decode slot was still occupied.
//   clk, rst_n          : clock, async active-low reset
//   load                : capture data_in/pc_in, mark full
//   unload              : contents have moved to the output slot, mark empty
//   clear               : flush (redirect), mark empty
//   data_in, pc_in      : word and its byte address
//   data, pc, full      : stored contents and occupancy
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      pc   <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      pc   <= pc_in;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: issues one memory request at a time, presents returned
// words to decode with a one-entry skid for backpressure, and handles
// redirects from execute (including ones that race an outstanding request).
//   clk, rst_n        : clock, async active-low reset
//   stall_i           : decode cannot accept ir_o this cycle
//   redirect_i        : taken branch/jump, flush and refetch from redirect_pc_i
//   redirect_pc_i     : new fetch target
//   imem              : instruction memory bus (master side)
//   ir_o, pc_o        : instruction and its byte address
//   valid_o           : ir_o/pc_o hold a live instruction
//
// State | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request to imem_addr_o outstanding
// FULL  | output and skid both occupied, no request
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          ir_o,
  output logic [31:0]          pc_o,
  output logic                 valid_o
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;   // next address to fetch; differs from imem_addr_o only while kill is set
  logic         kill;       // outstanding request belongs to a flushed path
  logic         slot_free;
  logic         ack_req;
  logic         skid_load;
  logic         skid_unload;
  logic [31:0]  skid_data;
  logic [31:0]  skid_pc;
  logic         skid_full;

  assign slot_free   = !valid_o || !stall_i;
  assign ack_req     = (state == ST_REQ) && imem.imem_ack_i;
  assign skid_load   = ack_req && !redirect_i && !kill && !slot_free;
  assign skid_unload = (state == ST_FULL) && skid_full && !redirect_i && slot_free;

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (redirect_i),
    .data_in (imem.imem_data_i),
    .pc_in   (imem.imem_addr_o),
    .data    (skid_data),
    .pc      (skid_pc),
    .full    (skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      fetch_pc         <= RESET_PC;
      kill             <= 1'b0;
      imem.imem_req_o  <= 1'b0;
      imem.imem_addr_o <= RESET_PC;
      ir_o             <= '0;
      pc_o             <= '0;
      valid_o          <= 1'b0;
    end else begin
      // consumed by decode unless something new lands below
      if (valid_o && !stall_i) valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          state           <= ST_REQ;
          imem.imem_req_o <= 1'b1;
          if (redirect_i) begin
            fetch_pc         <= redirect_pc_i;
            imem.imem_addr_o <= redirect_pc_i;
          end else begin
            imem.imem_addr_o <= fetch_pc;
          end
        end

        ST_REQ: begin
          if (redirect_i) begin
            valid_o  <= 1'b0;
            fetch_pc <= redirect_pc_i;
            if (imem.imem_ack_i) begin
              // request completes now; its data is dropped
              imem.imem_addr_o <= redirect_pc_i;
              kill             <= 1'b0;
            end else begin
              // address must stay stable until the stale ack arrives
              kill <= 1'b1;
            end
          end else if (imem.imem_ack_i) begin
            if (kill) begin
              kill             <= 1'b0;
              imem.imem_addr_o <= fetch_pc;
            end else begin
              fetch_pc         <= next_pc(fetch_pc);
              imem.imem_addr_o <= next_pc(fetch_pc);
              if (slot_free) begin
                ir_o    <= imem.imem_data_i;
                pc_o    <= imem.imem_addr_o;
                valid_o <= 1'b1;
              end else begin
                state           <= ST_FULL;
                imem.imem_req_o <= 1'b0;
              end
            end
          end
        end

        ST_FULL: begin
          if (redirect_i) begin
            valid_o          <= 1'b0;
            fetch_pc         <= redirect_pc_i;
            imem.imem_addr_o <= redirect_pc_i;
            imem.imem_req_o  <= 1'b1;
            state            <= ST_REQ;
          end else if (slot_free) begin
            ir_o            <= skid_data;
            pc_o            <= skid_pc;
            valid_o         <= 1'b1;
            imem.imem_req_o <= 1'b1;
            state           <= ST_REQ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage. Memory returns ~addr as the instruction
// word with a programmable ack latency; a second instance with
// RESET_PC=FFFF_FFF8 and a latency-1 memory exercises address wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] ir_o, pc_o;
  logic        valid_o;
  logic [31:0] ir2, pc2;
  logic        valid2;

  int n_tests = 0;
  int n_fail  = 0;

  int   lat = 1;
  int   cnt = 0;
  logic mem_ack = 1'b0;
  logic force_ack = 1'b0;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .ir_o          (ir_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem          (bus2),
    .ir_o          (ir2),
    .pc_o          (pc2),
    .valid_o       (valid2)
  );

  always #5 clk = ~clk;

  // memory: ack on the lat-th cycle of a request, data = ~addr
  assign bus.imem_ack_i   = mem_ack | force_ack;
  assign bus.imem_data_i  = ~bus.imem_addr_o;
  assign bus2.imem_ack_i  = bus2.imem_req_o;
  assign bus2.imem_data_i = ~bus2.imem_addr_o;

  always @(negedge clk) begin
    if (!rst_n || !bus.imem_req_o) begin
      cnt     = 0;
      mem_ack = 1'b0;
    end else if (cnt + 1 >= lat) begin
      cnt     = 0;
      mem_ack = 1'b1;
    end else begin
      cnt     = cnt + 1;
      mem_ack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    force_ack     = 1'b0;
    lat           = l;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] wrap_exp [3];
  logic [31:0] e;
  logic        found;

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // reset values, then streaming with latency 1
    lat = 1;
    repeat (2) tick();
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    check("rst_addr", bus.imem_addr_o, 32'h0);
    check("rst_ir", ir_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_addr_wrap", bus2.imem_addr_o, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    tick();
    check("idle_valid", {31'b0, valid_o}, 32'd0);
    check("first_req", {31'b0, bus.imem_req_o}, 32'd1);
    check("first_addr", bus.imem_addr_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 32'(i * 4);
      check("seq_valid", {31'b0, valid_o}, 32'd1);
      check("seq_pc", pc_o, e);
      check("seq_ir", ir_o, ~e);
      if (i < 3) begin
        check("wrap_valid", {31'b0, valid2}, 32'd1);
        check("wrap_pc", pc2, wrap_exp[i]);
        check("wrap_ir", ir2, ~wrap_exp[i]);
      end
    end

    // stall for 3 cycles while pc 4 is presented
    do_reset(1);
    repeat (3) tick();
    check("pre_stall_pc", pc_o, 32'h4);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", pc_o, 32'h4);
      check("stall_ir", ir_o, ~32'h4);
      check("stall_valid", {31'b0, valid_o}, 32'd1);
      check("stall_req", {31'b0, bus.imem_req_o}, 32'd0);
      if (k == 0) check("skid_full", {31'b0, dut.skid_full}, 32'd1);
    end
    stall_i = 1'b0;
    tick();
    check("unstall_pc8", pc_o, 32'h8);
    check("unstall_ir8", ir_o, ~32'h8);
    tick();
    check("unstall_pc12", pc_o, 32'hC);
    check("unstall_valid12", {31'b0, valid_o}, 32'd1);

    // latency 3, redirect while the request to 8 is outstanding
    do_reset(3);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus.imem_req_o && bus.imem_addr_o == 32'h8) found = 1'b1;
    end
    check("kill_reach8", {31'b0, found}, 32'd1);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    check("kill_valid", {31'b0, valid_o}, 32'd0);
    check("kill_addr_held", bus.imem_addr_o, 32'h8);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (valid_o) begin
        found = 1'b1;
        check("kill_next_pc", pc_o, 32'h40);
        check("kill_next_ir", ir_o, ~32'h40);
      end
    end
    check("kill_valid_seen", {31'b0, found}, 32'd1);

    // redirect coinciding with an ack
    do_reset(1);
    repeat (3) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    check("redir_ack_valid", {31'b0, valid_o}, 32'd0);
    check("redir_ack_addr", bus.imem_addr_o, 32'h100);
    check("redir_ack_req", {31'b0, bus.imem_req_o}, 32'd1);
    tick();
    check("redir_ack_v1", {31'b0, valid_o}, 32'd1);
    check("redir_ack_pc", pc_o, 32'h100);
    check("redir_ack_ir", ir_o, ~32'h100);
    tick();
    check("redir_ack_pc2", pc_o, 32'h104);

    // reset during an outstanding request, late ack lands in IDLE
    do_reset(3);
    repeat (4) tick();
    check("mid_valid", {31'b0, valid_o}, 32'd1);
    check("mid_pc", pc_o, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, valid_o}, 32'd0);
    check("mrst_ir", ir_o, 32'h0);
    check("mrst_pc", pc_o, 32'h0);
    check("mrst_req", {31'b0, bus.imem_req_o}, 32'd0);
    check("mrst_addr", bus.imem_addr_o, 32'h0);
    tick();
    rst_n     = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("idle_ack_valid", {31'b0, valid_o}, 32'd0);
    check("idle_ack_req", {31'b0, bus.imem_req_o}, 32'd1);
    check("idle_ack_addr", bus.imem_addr_o, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (valid_o) begin
        found = 1'b1;
        check("restart_pc", pc_o, 32'h0);
        check("restart_ir", ir_o, ~32'h0);
      end
    end
    check("restart_seen", {31'b0, found}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
